// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - signed SRAM-to-SRAM matrix multiply (C = A*B or A*B^T); optional MATMUL_SAT_EN clamps results
module matmul_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_trans_b,
    input  logic [ADDR_W-1:0] cmd_a_base,
    input  logic [ADDR_W-1:0] cmd_b_base,
    input  logic [ADDR_W-1:0] cmd_c_base,
    output logic              done,
    output logic              err,
    output logic              sat,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [DATA_W-1:0] a_rd_data,
    input  logic [DATA_W-1:0] b_rd_data,
    output logic              c_wr_en,
    output logic [ADDR_W-1:0] c_wr_addr,
    output logic [DATA_W-1:0] c_wr_data
);

    localparam int DW2 = DATA_W / 2;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHK, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              ready_q, trans_q, err_q, drain_q;
    logic [ADDR_W-1:0] a_base_q, b_base_q, c_base_q;
    logic [DW2-1:0]    m_dim_q, n_dim_q, k_dim_q;
    logic [DW2-1:0]    m_q, n_q, k_q;
    logic [ADDR_W-1:0] a_row_q, a_ptr_q, b_col_q, b_ptr_q, wr_idx_q;
    logic              v1_q, first1_q, last1_q, wr_q;
    logic signed [ACC_W-1:0] acc_q;

    logic                      accept;
    logic [DW2-1:0]            hdr_m, hdr_k, hdr_rb, hdr_cb, hdr_n;
    logic                      dim_bad, dim_zero;
    logic                      k_last, n_last, m_last;
    logic [ADDR_W-1:0]         k_addr, n_addr, b_step, b_col_nxt;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [DATA_W-1:0]         res;

    assign accept    = cmd_valid && ready_q;
    assign cmd_ready = ready_q;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

    // Header fields arrive from the SRAMs during CHK
    assign hdr_m    = a_rd_data[DATA_W-1:DW2];
    assign hdr_k    = a_rd_data[DW2-1:0];
    assign hdr_rb   = b_rd_data[DATA_W-1:DW2];
    assign hdr_cb   = b_rd_data[DW2-1:0];
    assign hdr_n    = trans_q ? hdr_rb : hdr_cb;
    assign dim_bad  = trans_q ? (hdr_cb != hdr_k) : (hdr_rb != hdr_k);
    assign dim_zero = (hdr_m == '0) || (hdr_n == '0) || (hdr_k == '0);

    assign k_last    = (k_q == k_dim_q - DW2'(1));
    assign n_last    = (n_q == n_dim_q - DW2'(1));
    assign m_last    = (m_q == m_dim_q - DW2'(1));
    assign k_addr    = ADDR_W'(k_dim_q);
    assign n_addr    = ADDR_W'(n_dim_q);
    // Along k, B^T walks a row (stride 1); plain B walks a column (stride N)
    assign b_step    = trans_q ? ADDR_W'(1) : n_addr;
    assign b_col_nxt = b_col_q + (trans_q ? k_addr : ADDR_W'(1));

    assign prod     = $signed(a_rd_data) * $signed(b_rd_data);
    assign prod_ext = ACC_W'(prod);

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic clamp_hi, clamp_lo, sat_q;
    assign clamp_hi = (acc_q > SAT_MAX);
    assign clamp_lo = (acc_q < SAT_MIN);
    assign res = clamp_hi ? SAT_MAX[DATA_W-1:0] :
                 clamp_lo ? SAT_MIN[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign sat = sat_q;

    // Sticky clamp flag, cleared when a new command is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          sat_q <= 1'b0;
        else if (accept)                       sat_q <= 1'b0;
        else if (wr_q && (clamp_hi || clamp_lo)) sat_q <= 1'b1;
    end
`else
    assign res = acc_q[DATA_W-1:0];
    assign sat = 1'b0;
`endif

    // State register; cmd_ready is registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
        end
    end

    // Next-state and SRAM port drive
    always_comb begin
        state_d   = state_q;
        a_rd_addr = '0;
        b_rd_addr = '0;
        c_wr_en   = 1'b0;
        c_wr_addr = '0;
        c_wr_data = '0;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_HDR;
            S_HDR: begin
                a_rd_addr = a_base_q;
                b_rd_addr = b_base_q;
                state_d   = S_CHK;
            end
            S_CHK: begin
                if (dim_bad) begin
                    state_d = S_DONE;
                end else begin
                    c_wr_en   = 1'b1;
                    c_wr_addr = c_base_q;
                    c_wr_data = {hdr_m, hdr_n};
                    state_d   = dim_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                a_rd_addr = a_ptr_q;
                b_rd_addr = b_ptr_q;
                if (k_last && n_last && m_last) state_d = S_DRAIN;
            end
            S_DRAIN: if (drain_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wr_q) begin
            c_wr_en   = 1'b1;
            c_wr_addr = c_base_q + ADDR_W'(1) + wr_idx_q;
            c_wr_data = res;
        end
    end

    // Command latch, dimension capture and m/n/k address walk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trans_q  <= 1'b0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            err_q    <= 1'b0;
            m_dim_q  <= '0;
            n_dim_q  <= '0;
            k_dim_q  <= '0;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_row_q  <= '0;
            a_ptr_q  <= '0;
            b_col_q  <= '0;
            b_ptr_q  <= '0;
            drain_q  <= 1'b0;
        end else begin
            drain_q <= (state_q == S_DRAIN) && !drain_q;
            if (accept) begin
                trans_q  <= cmd_trans_b;
                a_base_q <= cmd_a_base;
                b_base_q <= cmd_b_base;
                c_base_q <= cmd_c_base;
                err_q    <= 1'b0;
            end
            if (state_q == S_CHK) begin
                err_q   <= dim_bad;
                m_dim_q <= hdr_m;
                n_dim_q <= hdr_n;
                k_dim_q <= hdr_k;
                m_q     <= '0;
                n_q     <= '0;
                k_q     <= '0;
                a_row_q <= a_base_q + ADDR_W'(1);
                a_ptr_q <= a_base_q + ADDR_W'(1);
                b_col_q <= b_base_q + ADDR_W'(1);
                b_ptr_q <= b_base_q + ADDR_W'(1);
            end else if (state_q == S_RUN) begin
                if (!k_last) begin
                    k_q     <= k_q + DW2'(1);
                    a_ptr_q <= a_ptr_q + ADDR_W'(1);
                    b_ptr_q <= b_ptr_q + b_step;
                end else begin
                    k_q <= '0;
                    if (n_last) begin
                        n_q     <= '0;
                        m_q     <= m_q + DW2'(1);
                        a_row_q <= a_row_q + k_addr;
                        a_ptr_q <= a_row_q + k_addr;
                        b_col_q <= b_base_q + ADDR_W'(1);
                        b_ptr_q <= b_base_q + ADDR_W'(1);
                    end else begin
                        n_q     <= n_q + DW2'(1);
                        a_ptr_q <= a_row_q;
                        b_col_q <= b_col_nxt;
                        b_ptr_q <= b_col_nxt;
                    end
                end
            end
        end
    end

    // MAC pipeline: data lands one cycle after issue, result written the cycle after
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            wr_q     <= 1'b0;
            wr_idx_q <= '0;
            acc_q    <= '0;
        end else begin
            v1_q     <= (state_q == S_RUN);
            first1_q <= (k_q == '0);
            last1_q  <= k_last;
            wr_q     <= v1_q && last1_q;
            if (v1_q)
                acc_q <= (first1_q ? '0 : acc_q) + prod_ext;
            if (state_q == S_CHK)
                wr_idx_q <= '0;
            else if (wr_q)
                wr_idx_q <= wr_idx_q + ADDR_W'(1);
        end
    end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised signed matrix-multiply engine that computes C = A·B or C = A·Bᵀ from operands held in single-port SRAMs. It writes the result, with its dimension header, to a result SRAM. It generalises the fixed 32-bit, input/weight/result datapath to configurable data, address and accumulator widths, runtime base addresses and a transpose mode. Future attention stages (QKV projection, S = Q·Kᵀ, Z = S·V) reuse it as a single command-driven core.

## Interface
- DATA_W, 32: SRAM word width. Dimension fields are DATA_W/2 bits each.
- ADDR_W, 16: SRAM address width.
- ACC_W, 64: internal signed accumulator width; must be ≥ 2·DATA_W.
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted on cmd_valid&&cmd_ready
- cmd_trans_b  in  1  0: C=A·B, 1: C=A·Bᵀ
- cmd_a_base, cmd_b_base, cmd_c_base  in  ADDR_W each  header address of A, B, C
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; dimension mismatch
- sat  out  1  valid with done; any result clamped (0 without MATMUL_SAT_EN)
- a_rd_addr / b_rd_addr  out  ADDR_W  operand read addresses
- a_rd_data / b_rd_data  in  DATA_W  read data, one cycle after address
- c_wr_en  out  1  result write strobe
- c_wr_addr  out  ADDR_W  result write address
- c_wr_data  out  DATA_W  result write data

## Operation
- Header word: rows in [DATA_W-1:DATA_W/2], cols in [DATA_W/2-1:0]. Elements are row-major from base+1.
- A is M×K. B header is R_b×C_b.
  - trans_b=0: requires R_b==K; N=C_b; B[k][n] at b_base+1+k·N+n.
  - trans_b=1: requires C_b==K; N=R_b; operand at b_base+1+n·K+k.
- C[m][n] is written at c_base+1+m·N+n in order m-major, n-minor. The header {M,N} is written at c_base.
- Command fields are latched on acceptance; inputs are ignored while cmd_ready=0.
- States and transitions:
  - IDLE → HDR on acceptance.
  - HDR: drive a_base and b_base.
  - CHK: latch dimensions.
    - Mismatch → DONE with err=1 and no writes.
    - M, N or K zero → write header only → DONE.
    - Otherwise write header → RUN.
  - RUN: issue one A/B address pair per cycle, k innermost, for M·N·K cycles → DRAIN.
  - DRAIN: 2 cycles → DONE.
  - DONE: done=1 → IDLE.
- Arithmetic:
  - Signed DATA_W×DATA_W product, sign-extended into an ACC_W accumulator that wraps mod 2^ACC_W.
  - The accumulator clears at the first k of each element; there is no bubble between elements.
  - Result conversion depends on MATMUL_SAT_EN (see Configuration).
- Address arithmetic wraps mod 2^ADDR_W.
- Reset mid-operation: state returns to IDLE immediately and no further writes occur. C contents are undefined.

## Timing
- Reset values: cmd_ready=0, done=0, err=0, sat=0, c_wr_en=0, all addresses and c_wr_data=0.
- cmd_ready rises on the first clk edge after reset_n deasserts and is registered.
- Acceptance cycle T:
  - cmd_ready falls at T+1.
  - HDR occupies T+1; CHK occupies T+2.
  - The header write (c_wr_en=1) occurs in cycle T+2.
- Element writes: the write of element e occurs exactly 2 cycles after the issue of its last (k=K-1) address pair. Consecutive elements are written K cycles apart.
- done asserts in cycle T+M·N·K+5 for a full run, and in cycle T+3 for err or a zero dimension.
- cmd_ready reasserts in the cycle after done.
- err and sat are held until the next acceptance.

## Configuration
- MATMUL_SAT_EN defined:
  - The accumulator is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] on write.
  - sat is sticky for the command when any element clamps.
- MATMUL_SAT_EN undefined:
  - The low DATA_W bits of the accumulator are written.
  - sat is tied 0 and the clamp logic is absent.

## Test plan
- A=2×3 {1,2,3;4,5,6}, B=3×2 {7,8;9,10;11,12}, trans_b=0, c_base=0x40 → header 0x00020002 at 0x40, then 58,64,139,154 at 0x41–0x44; done at T+17.
- Same A, B stored 2×3 {7,9,11;8,10,12}, trans_b=1 → identical C and timing.
- A 2×3, B header 2×2 with trans_b=0 → err=1 and done at T+3, with no c_wr_en.
- A 1×1 {0x7FFFFFFF}, B 1×1 {2}, DATA_W=32 → with macro 0x7FFFFFFF and sat=1; without, 0xFFFFFFFE and sat=0.
- Start a 4×4·4×4 command, pulse reset_n low at T+20 → outputs return to reset values asynchronously, no further writes, cmd_ready=1 one cycle after release; a new command then completes correctly.
- Back-to-back commands with cmd_valid held high → the second is accepted in the cycle after the first done, and cmd_valid pulses during busy are ignored.
